// File: rtl/alu_bus_sequencer.sv
// Bus-master sequencer for alu32: fetch two operands, execute, write the result back, pulse done.
// Optional ALU_FLAG_WB_EN adds a second write beat carrying {c,n,z,v} to addr_d+1.
module alu_bus_sequencer #(
   parameter int ADDR_W        = 8,
   parameter int GRANT_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op_sel,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [ADDR_W-1:0] addr_d,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       result_q,
   output logic              c_q,
   output logic              n_q,
   output logic              z_q,
   output logic              v_q,
   output logic              m_req,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_dout,
   input  logic [31:0]       m_din,
   input  logic              m_grant,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [2:0]        alu_op,
   input  logic [31:0]       alu_result,
   input  logic              alu_c,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_v
);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_RD_A, S_RD_B, S_CAP_B, S_EXEC, S_WB, S_WBF, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_d_q;
   logic [31:0]       opa_q;
   logic [31:0]       alu_a_q, alu_b_q;
   logic [2:0]        alu_op_q;
   logic              err_q, err_d;

   assign err    = err_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = alu_op_q;

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      m_req   = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_dout  = '0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_ARB;
         end
         S_ARB: begin
            m_req  = 1'b1;
            m_addr = addr_a_q;
            if (m_grant) begin
               state_d = S_RD_A;
            end else if (cnt_q == 8'(GRANT_TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end
         end
         S_RD_A: begin
            m_req  = 1'b1;
            m_addr = addr_a_q;
            if (m_grant) state_d = S_RD_B;
            else begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end
         end
         S_RD_B: begin
            m_req  = 1'b1;
            m_addr = addr_b_q;
            if (m_grant) state_d = S_CAP_B;
            else begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end
         end
         S_CAP_B: begin
            m_req   = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            m_req   = 1'b1;
            state_d = S_WB;
         end
         S_WB: begin
            m_req  = 1'b1;
            m_wr   = 1'b1;
            m_addr = addr_d_q;
            m_dout = result_q;
            if (!m_grant) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
`ifdef ALU_FLAG_WB_EN
               state_d = S_WBF;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef ALU_FLAG_WB_EN
         S_WBF: begin
            m_req  = 1'b1;
            m_wr   = 1'b1;
            m_addr = addr_d_q + ADDR_W'(1);
            m_dout = {28'b0, c_q, n_q, z_q, v_q};
            if (m_grant) state_d = S_DONE;
            else begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         op_q     <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         addr_d_q <= '0;
         opa_q    <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q     <= op_sel;
                  addr_a_q <= addr_a;
                  addr_b_q <= addr_b;
                  addr_d_q <= addr_d;
                  cnt_q    <= '0;
               end
            end
            S_ARB:  if (!m_grant) cnt_q <= cnt_q + 8'd1;
            S_RD_B: opa_q <= m_din;
            // Operand B goes straight into the ALU b register; it is stable for all of EXEC.
            S_CAP_B: begin
               alu_a_q  <= opa_q;
               alu_b_q  <= m_din;
               alu_op_q <= op_q;
            end
            S_EXEC: begin
               result_q <= alu_result;
               c_q      <= alu_c;
               n_q      <= alu_n;
               z_q      <= alu_z;
               v_q      <= alu_v;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Directed bench for alu_bus_sequencer with a behavioural bus slave and alu32 model.
module tb_alu_bus_sequencer;

`ifdef ALU_FLAG_WB_EN
   localparam int LAT = 8;
   localparam int NWR = 2;
`else
   localparam int LAT = 7;
   localparam int NWR = 1;
`endif

   logic        clk = 1'b0;
   logic        reset, start, m_grant;
   logic [2:0]  op_sel;
   logic [7:0]  addr_a, addr_b, addr_d;
   logic        busy, done, err, c_q, n_q, z_q, v_q;
   logic [31:0] result_q;
   logic        m_req, m_wr;
   logic [7:0]  m_addr;
   logic [31:0] m_dout, m_din;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        alu_c, alu_n, alu_z, alu_v;

   logic [31:0] rom  [256];
   logic [31:0] wmem [256];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   alu_bus_sequencer #(.ADDR_W(8), .GRANT_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
      .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
      .busy(busy), .done(done), .err(err), .result_q(result_q),
      .c_q(c_q), .n_q(n_q), .z_q(z_q), .v_q(v_q),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
      .m_din(m_din), .m_grant(m_grant),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v)
   );

   // alu32 model: carry on subtract is the carry-out of a + ~b + 1
   always_comb begin
      logic [32:0] s;
      s          = '0;
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_op)
         3'd0: alu_result = '0;
         3'd1: alu_result = ~alu_a;
         3'd2: alu_result = alu_a & alu_b;
         3'd3: alu_result = alu_a | alu_b;
         3'd4: alu_result = alu_a ^ alu_b;
         3'd5: alu_result = ~(alu_a ^ alu_b);
         3'd6: begin
            s          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = s[31:0];
            alu_c      = s[32];
            alu_v      = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
         end
         default: begin
            s          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            alu_result = s[31:0];
            alu_c      = s[32];
            alu_v      = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
         end
      endcase
      alu_n = alu_result[31];
      alu_z = (alu_result == 32'd0);
   end

   always @(posedge clk) begin
      if (m_req && m_grant) begin
         if (m_wr) begin
            wmem[m_addr] <= m_dout;
            wr_cnt       <= wr_cnt + 1;
         end else begin
            m_din  <= rom[m_addr];
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [7:0] d, output int cycles);
      int n;
      rom[1] = a;
      rom[2] = b;
      op_sel = op; addr_a = 8'd1; addr_b = 8'd2; addr_d = d;
      start  = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         step();
         n++;
      end
      cycles = done ? n : -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({busy, done, err, m_req, m_wr, c_q, n_q, z_q, v_q} !== 9'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000000",
                  {busy, done, err, m_req, m_wr, c_q, n_q, z_q, v_q});
      end
      checks++;
      if ({result_q, alu_a, alu_b, alu_op, m_addr, m_dout} !== '0) begin
         errors++;
         $display("FAIL reset_data: result %h alu_a %h alu_b %h op %0d addr %h dout %h expected all 0",
                  result_q, alu_a, alu_b, alu_op, m_addr, m_dout);
      end
      reset = 1'b0;
   endtask

   task automatic test_add();
      int cyc;
      run_op(32'd5, 32'd7, 3'd6, 8'd3, cyc);
      checks++;
      if (cyc !== LAT) begin errors++; $display("FAIL add_latency: got %0d expected %0d", cyc, LAT); end
      checks++;
      if (result_q !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected 0000000c", result_q); end
      checks++;
      if ({c_q, n_q, z_q, v_q} !== 4'b0000) begin
         errors++; $display("FAIL add_flags: got %b expected 0000", {c_q, n_q, z_q, v_q});
      end
      checks++;
      if (wmem[3] !== 32'd12) begin errors++; $display("FAIL add_wb: got %h expected 0000000c", wmem[3]); end
`ifdef ALU_FLAG_WB_EN
      checks++;
      if (wmem[4] !== 32'd0) begin errors++; $display("FAIL add_flag_wb: got %h expected 00000000", wmem[4]); end
`endif
      checks++;
      if ({busy, m_req, err} !== 3'b100) begin
         errors++; $display("FAIL add_done_state: busy,m_req,err got %b expected 100", {busy, m_req, err});
      end
      step();
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++; $display("FAIL add_done_pulse: done,busy got %b expected 00", {done, busy});
      end
   endtask

   task automatic test_sub();
      int cyc;
      run_op(32'd3, 32'd5, 3'd7, 8'd3, cyc);
      checks++;
      if (result_q !== 32'hFFFF_FFFE || cyc !== LAT) begin
         errors++; $display("FAIL sub_result: got %h in %0d cycles expected fffffffe in %0d", result_q, cyc, LAT);
      end
      checks++;
      if ({c_q, n_q, z_q, v_q} !== 4'b0100) begin
         errors++; $display("FAIL sub_flags: got %b expected 0100", {c_q, n_q, z_q, v_q});
      end
      step();
   endtask

   task automatic test_overflow();
      int cyc;
      run_op(32'h7FFF_FFFF, 32'd1, 3'd6, 8'd3, cyc);
      checks++;
      if (result_q !== 32'h8000_0000 || wmem[3] !== 32'h8000_0000) begin
         errors++; $display("FAIL ovf_result: got %h mem %h expected 80000000", result_q, wmem[3]);
      end
      checks++;
      if ({c_q, n_q, z_q, v_q} !== 4'b0101) begin
         errors++; $display("FAIL ovf_flags: got %b expected 0101", {c_q, n_q, z_q, v_q});
      end
      step();
      step();
      checks++;
      if (alu_a !== 32'h7FFF_FFFF || alu_b !== 32'd1 || alu_op !== 3'd6) begin
         errors++; $display("FAIL alu_hold: got a %h b %h op %0d expected 7fffffff 00000001 6", alu_a, alu_b, alu_op);
      end
   endtask

   task automatic test_grant_loss();
      int w0;
      w0 = wr_cnt;
      rom[1] = 32'd9; rom[2] = 32'd9;
      op_sel = 3'd6; addr_a = 8'd1; addr_b = 8'd2; addr_d = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      m_grant = 1'b0;
      step();
      checks++;
      if ({err, m_req, busy, done} !== 4'b1000) begin
         errors++; $display("FAIL gl_abort: err,m_req,busy,done got %b expected 1000", {err, m_req, busy, done});
      end
      checks++;
      if (result_q !== 32'h8000_0000 || {c_q, n_q, z_q, v_q} !== 4'b0101) begin
         errors++; $display("FAIL gl_result_kept: got %h/%b expected 80000000/0101", result_q, {c_q, n_q, z_q, v_q});
      end
      checks++;
      if (wr_cnt !== w0) begin errors++; $display("FAIL gl_no_write: got %0d writes expected 0", wr_cnt - w0); end
      m_grant = 1'b1;
      step();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL gl_err_pulse: got %b expected 0", err); end
   endtask

   task automatic test_zero();
      int cyc;
      run_op(32'h1234, 32'h5678, 3'd0, 8'd5, cyc);
      checks++;
      if (cyc !== LAT || result_q !== 32'd0 || wmem[5] !== 32'd0) begin
         errors++; $display("FAIL zero_result: got %h mem %h in %0d cycles expected 0 0 in %0d", result_q, wmem[5], cyc, LAT);
      end
      checks++;
      if ({c_q, n_q, z_q, v_q} !== 4'b0010) begin
         errors++; $display("FAIL zero_flags: got %b expected 0010", {c_q, n_q, z_q, v_q});
      end
      step();
   endtask

   task automatic test_busy_ignore();
      int n, w0, bcnt;
      w0 = wr_cnt;
      rom[1] = 32'd100; rom[2] = 32'd23;
      op_sel = 3'd6; addr_a = 8'd1; addr_b = 8'd2; addr_d = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1; op_sel = 3'd0; addr_d = 8'd9;
      step();
      start = 1'b0;
      n = 3;
      while (!done && n < 40) begin step(); n++; end
      checks++;
      if (n !== LAT || result_q !== 32'd123 || wmem[3] !== 32'd123) begin
         errors++; $display("FAIL busy_first_job: got %h mem %h at %0d expected 0000007b at %0d", result_q, wmem[3], n, LAT);
      end
      bcnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy) bcnt++;
      end
      checks++;
      if (bcnt !== 0 || wr_cnt - w0 !== NWR) begin
         errors++; $display("FAIL busy_no_queue: busy %0d cycles, %0d writes expected 0, %0d", bcnt, wr_cnt - w0, NWR);
      end
   endtask

   task automatic test_timeout();
      int n, w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      m_grant = 1'b0;
      op_sel = 3'd6; addr_a = 8'd1; addr_b = 8'd2; addr_d = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (!err && n < 40) begin step(); n++; end
      checks++;
      if (n !== 16) begin errors++; $display("FAIL timeout_cycles: err after %0d cycles expected 16", n); end
      checks++;
      if ({err, m_req, busy, done, m_addr} !== {4'b1000, 8'd0}) begin
         errors++; $display("FAIL timeout_state: err,m_req,busy,done got %b addr %h expected 1000 00",
                            {err, m_req, busy, done}, m_addr);
      end
      checks++;
      if (wr_cnt !== w0 || rd_cnt !== r0) begin
         errors++; $display("FAIL timeout_no_beats: got %0d writes %0d reads expected 0 0", wr_cnt - w0, rd_cnt - r0);
      end
      m_grant = 1'b1;
      step();
   endtask

   task automatic test_reset_exec();
      rom[1] = 32'd5; rom[2] = 32'd7;
      op_sel = 3'd6; addr_a = 8'd1; addr_b = 8'd2; addr_d = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7 || m_req !== 1'b1) begin
         errors++; $display("FAIL exec_operands: got a %h b %h req %b expected 5 7 1", alu_a, alu_b, m_req);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({busy, done, err, m_req, m_wr, c_q, n_q, z_q, v_q} !== 9'd0 ||
          {result_q, alu_a, alu_b, alu_op, m_addr, m_dout} !== '0) begin
         errors++; $display("FAIL reset_exec: ctrl %b result %h alu_a %h expected all 0",
                            {busy, done, err, m_req, m_wr, c_q, n_q, z_q, v_q}, result_q, alu_a);
      end
      reset = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_exec_idle: busy got %b expected 0", busy); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      reset = 1'b1; start = 1'b0; m_grant = 1'b1;
      op_sel = '0; addr_a = '0; addr_b = '0; addr_d = '0;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_grant_loss();
      test_zero();
      test_busy_ignore();
      test_timeout();
      test_reset_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
